// File: rtl/sub32_pipe_if.sv
// Operand/result handshake bundle for sub32_pipe: valid/ready on the operand
// side and on the result side, plus the ALU-style flags.
interface sub32_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Diff;
    logic        Bout;
    logic        V;
    logic        Z;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, V, Z
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, V, Z
    );
endinterface

// File: rtl/sub32_pipe.sv
// Four-stage stallable 32-bit subtractor: stage k resolves byte k by
// borrow-select, S3 also registers the Bout/V/Z flags.
module sub32_pipe (
    input  logic        clk,
    input  logic        rst_n,
    sub32_pipe_if.slave bus
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        br;
    } stage_t;

    stage_t      src     [4];
    stage_t      stage_d [4];
    stage_t      stage_q [3];
    logic [8:0]  res;

    logic [3:0]  vld_q;
    logic [3:0]  vld_d;
    logic [3:0]  load;
    logic [3:0]  adv;
    logic        adv0, adv1, adv2, adv3;
    logic        accept;

    logic [31:0] diff_q;
    logic        bout_q;
    logic        ovf_q;
    logic        zero_q;
    logic        ovf_d;
    logic        zero_d;
    logic        unused_bits;

    // Both borrow-in candidates are formed, then the incoming borrow picks one;
    // bit 8 of each 9-bit difference is that candidate's borrow-out.
    function automatic logic [8:0] slice_sub(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic       bin);
        logic [8:0] d0;
        logic [8:0] d1;
        d0 = {1'b0, a} - {1'b0, b};
        d1 = {1'b0, a} - {1'b0, b} - 9'd1;
        return bin ? d1 : d0;
    endfunction

    // Backpressure ripples combinationally from out_ready down to in_ready.
    assign adv3   = vld_q[3] & bus.out_ready;
    assign adv2   = vld_q[2] & (~vld_q[3] | adv3);
    assign adv1   = vld_q[1] & (~vld_q[2] | adv2);
    assign adv0   = vld_q[0] & (~vld_q[1] | adv1);
    assign adv    = {adv3, adv2, adv1, adv0};

    assign bus.in_ready = ~vld_q[0] | adv0;
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = {adv2, adv1, adv0, accept};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            vld_d[k] = load[k] | (vld_q[k] & ~adv[k]);
        end
    end

    // NOTE: blocking '=' is correct here: src and res are scratch values that
    // must update in program order inside one evaluation; state uses '<='.
    always_comb begin
        // NOTE: every target gets a value on every pass, so no latch is inferred.
        res    = '0;
        src[0] = '{a: bus.A, b: bus.B, d: 32'd0, br: bus.Bin};
        for (int k = 1; k < 4; k++) begin
            src[k] = stage_q[k-1];
        end
        for (int k = 0; k < 4; k++) begin
            res                    = slice_sub(src[k].a[8*k +: 8], src[k].b[8*k +: 8], src[k].br);
            stage_d[k]             = src[k];
            stage_d[k].d[8*k +: 8] = res[7:0];
            stage_d[k].br          = res[8];
        end
    end

    assign ovf_d  = (stage_d[3].a[31] ^ stage_d[3].b[31]) & (stage_d[3].d[31] ^ stage_d[3].a[31]);
    assign zero_d = (stage_d[3].d == 32'd0);

    // Only the sign bits of the operands matter once the last byte is resolved.
    assign unused_bits = ^{stage_d[3].a[30:0], stage_d[3].b[30:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (load[3]) begin
                diff_q <= stage_d[3].d;
                bout_q <= stage_d[3].br;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    // NOTE: internal stage data is left out of reset; it is ignored whenever
    // its valid bit is low, so a reset mux would buy nothing.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (load[k]) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign bus.out_valid = vld_q[3];
    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.V         = ovf_q;
    assign bus.Z         = zero_q;

endmodule

// File: tb/tb_sub32_pipe.sv
// Self-checking bench for sub32_pipe: directed vector table with latency
// checks, backpressure, randomized bubbles against a reference model, reset.
module tb_sub32_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        v;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        v;
        logic        z;
    } exp_t;

    logic clk;
    logic rst_n;
    sub32_pipe_if bus ();

    sub32_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          n_in;
    int          n_out;
    exp_t        model_q[$];
    logic        held;
    logic [31:0] held_diff;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: plain wide-integer arithmetic, no slicing.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t            r;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        ua     = longint'(a);
        ub     = longint'(b) + longint'(bin);
        sr     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        r.diff = a - b - {31'd0, bin};
        r.bout = (ua < ub);
        r.v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.z    = (r.diff == 32'd0);
        return r;
    endfunction

    // One cycle: drive at negedge, predict both handshakes for the next posedge.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.Bin       = bin;
        bus.out_ready = ordy;
        #1;
        if (held) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_diff", bus.Diff, held_diff);
        end
        if (bus.out_valid && ordy) begin
            if (model_q.size() == 0) begin
                check("spurious_out", bus.out_valid, 1'b0);
            end else begin
                e = model_q.pop_front();
                check("diff", bus.Diff, e.diff);
                check("bout", bus.Bout, e.bout);
                check("v",    bus.V,    e.v);
                check("z",    bus.Z,    e.z);
                n_out++;
            end
        end
        held      = bus.out_valid && !ordy;
        held_diff = bus.Diff;
        acc       = iv && bus.in_ready;
        if (acc) begin
            model_q.push_back(ref_model(a, b, bin));
            n_in++;
        end
    endtask

    task automatic run_vec(input vec_t t);
        int lat;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.A         = t.a;
        bus.B         = t.b;
        bus.Bin       = t.bin;
        bus.out_ready = 1'b1;
        #1;
        check("vec_in_ready", bus.in_ready, 1'b1);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) lat = c;
        end
        check("vec_latency", lat, 4);
        check("vec_diff", bus.Diff, t.diff);
        check("vec_bout", bus.Bout, t.bout);
        check("vec_v",    bus.V,    t.v);
        check("vec_z",    bus.Z,    t.z);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        int          idx;
        int          n0;
        int          n_acc_r;
        int          cyc;
        logic [31:0] bp_a [8];
        logic [31:0] bp_b [8];
        logic [31:0] ra;
        logic [31:0] rb;

        n_cmp = 0;
        n_bad = 0;
        n_in  = 0;
        n_out = 0;
        held  = 1'b0;
        held_diff = '0;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

        // Reset state
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_diff",      bus.Diff,      32'd0);
        check("rst_flags",     {bus.Bout, bus.V, bus.Z}, 3'b000);

        // Directed vectors with latency
        foreach (vecs[i]) run_vec(vecs[i]);
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Backpressure: 6 beats offered while the consumer stalls
        foreach (bp_a[i]) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(idx < 6, bp_a[idx], bp_b[idx], idx[0], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepts",  idx, 4);
        check("bp_in_ready", bus.in_ready, 1'b0);
        check("bp_out_valid", bus.out_valid, 1'b1);
        n0 = n_out;
        for (int c = 0; c < 6; c++) begin
            step(idx < 6, bp_a[idx], bp_b[idx], idx[0], 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_drain_rate", n_out - n0, 6);
        check("bp_all_in", idx, 6);

        // Random bubbles on both sides
        n0      = n_out;
        n_acc_r = 0;
        cyc     = 0;
        while (n_acc_r < 1000 && cyc < 20000) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
            step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, acc);
            if (acc) n_acc_r++;
            cyc++;
        end
        check("rand_accepts", n_acc_r, 1000);
        for (int c = 0; c < 20 && model_q.size() > 0; c++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        check("rand_drain", model_q.size(), 0);
        check("rand_count", n_out - n0, 1000);

        // Reset with three beats in flight
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 32'($urandom), 32'($urandom), 1'b0, 1'b0, acc);
        end
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = 32'h0000_0009;
        bus.B        = 32'h0000_0001;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_diff",      bus.Diff,      32'd0);
        check("mid_rst_in_ready",  bus.in_ready,  1'b1);
        model_q.delete();
        held = 1'b0;
        n0   = n_out;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        check("mid_rst_no_stale", n_out - n0, 0);
        check("mid_rst_idle_valid", bus.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
